// File: rtl/handshake_constant_match.sv
// Sink of a constant-token dataflow path: compares each accepted token against CONST_VALUE,
// emits a registered 1-bit match result and keeps saturating match/mismatch statistics.
module handshake_constant_match #(
    parameter int                    DATA_WIDTH  = 33,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = 33'h0A9F18CCE,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic                   outs,
    output logic                   outs_valid,
    input  logic                   outs_ready,
    input  logic                   cnt_clear,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic [COUNT_WIDTH-1:0] mismatch_count,
    output logic                   err
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic in_xfer;
    logic out_xfer;
    logic is_match;

    // Slot may refill on the same edge it drains, giving full throughput.
    assign ins_ready = !outs_valid || outs_ready;
    assign in_xfer   = ins_valid && ins_ready;
    assign out_xfer  = outs_valid && outs_ready;
    assign is_match  = (ins == CONST_VALUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs       <= 1'b0;
            outs_valid <= 1'b0;
        end else if (in_xfer) begin
            outs       <= is_match;
            outs_valid <= 1'b1;
        end else if (out_xfer) begin
            outs_valid <= 1'b0;
        end
    end

    // Clear wins over a same-edge transfer; that token is produced but not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count    <= '0;
            mismatch_count <= '0;
            err            <= 1'b0;
        end else if (cnt_clear) begin
            match_count    <= '0;
            mismatch_count <= '0;
            err            <= 1'b0;
        end else if (in_xfer) begin
            if (is_match) begin
                if (match_count != CNT_MAX) begin
                    match_count <= match_count + 1'b1;
                end
            end else begin
                if (mismatch_count != CNT_MAX) begin
                    mismatch_count <= mismatch_count + 1'b1;
                end
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_constant_match.sv
// Self-checking bench: queue-based reference model of the result slot and plain integer
// statistics, checked every cycle against a 16-bit-counter and a 4-bit-counter instance.
module tb_handshake_constant_match;

    localparam logic [32:0] CV = 33'h0A9F18CCE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [32:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        outs_ready = 1'b0;
    logic        cnt_clear = 1'b0;

    logic        ins_ready, outs, outs_valid, err;
    logic [15:0] match_count, mismatch_count;
    logic        ins_ready4, outs4, outs_valid4, err4;
    logic [3:0]  match_count4, mismatch_count4;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit q[$];
    bit m_last = 1'b0;
    int m_mc = 0;
    int m_mmc = 0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    handshake_constant_match dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready), .cnt_clear(cnt_clear),
        .match_count(match_count), .mismatch_count(mismatch_count), .err(err)
    );

    handshake_constant_match #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
        .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready), .cnt_clear(cnt_clear),
        .match_count(match_count4), .mismatch_count(mismatch_count4), .err(err4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_last = 1'b0;
        m_mc   = 0;
        m_mmc  = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_model();
        bit exp_valid;
        bit exp_outs;
        exp_valid = (q.size() > 0);
        exp_outs  = exp_valid ? q[0] : m_last;
        chk("outs_valid", outs_valid, exp_valid);
        chk("outs", outs, exp_outs);
        chk("ins_ready", ins_ready, !exp_valid || outs_ready);
        chk("match_count", match_count, sat(m_mc, 65535));
        chk("mismatch_count", mismatch_count, sat(m_mmc, 65535));
        chk("err", err, m_err);
        chk("outs_valid4", outs_valid4, exp_valid);
        chk("outs4", outs4, exp_outs);
        chk("ins_ready4", ins_ready4, !exp_valid || outs_ready);
        chk("match_count4", match_count4, sat(m_mc, 15));
        chk("mismatch_count4", mismatch_count4, sat(m_mmc, 15));
        chk("err4", err4, m_err);
    endtask

    // advance the model to the state after the coming rising edge
    task automatic model_step();
        bit m_ready, in_x, out_x, hit;
        m_ready = (q.size() == 0) || outs_ready;
        in_x    = ins_valid && m_ready;
        out_x   = (q.size() > 0) && outs_ready;
        hit     = (ins == CV);
        if (out_x) void'(q.pop_front());
        if (in_x) begin
            q.push_back(hit);
            m_last = hit;
        end
        if (cnt_clear) begin
            m_mc = 0; m_mmc = 0; m_err = 1'b0;
        end else if (in_x) begin
            if (hit) m_mc++;
            else begin
                m_mmc++;
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [32:0] d, input logic ordy, input logic clr);
        @(negedge clk);
        ins_valid  = v;
        ins        = d;
        outs_ready = ordy;
        cnt_clear  = clr;
        #1;
        check_model();
        model_step();
    endtask

    initial begin
        logic [32:0] d;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs_valid", outs_valid, 1'b0);
        chk("reset_match_count", match_count, 16'd0);
        rst = 1'b1;

        // 1: single matching token
        step(0, '0, 1, 0);
        chk("ready_after_reset", ins_ready, 1'b1);
        step(1, CV, 1, 0);
        step(0, '0, 1, 0);
        chk("t1_outs", {outs_valid, outs}, 2'b11);
        chk("t1_match_count", match_count, 16'd1);
        chk("t1_err", err, 1'b0);

        // 2: LSB flip then MSB flip
        step(1, 33'h0A9F18CCF, 1, 0);
        step(1, 33'h1A9F18CCE, 1, 0);
        chk("t2_first_outs", outs, 1'b0);
        chk("t2_err_early", err, 1'b1);
        step(0, '0, 1, 0);
        chk("t2_mismatch_count", mismatch_count, 16'd2);

        // 3: back-to-back alternating stream
        for (int i = 0; i < 8; i++) begin
            step(1, (i % 2 == 0) ? CV : (CV ^ 33'h100), 1, 0);
            chk("t3_ready_held", ins_ready, 1'b1);
        end
        step(0, '0, 1, 0);

        // 4: backpressure with a full slot
        step(1, CV, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, CV ^ 33'h1, 0, 0);
            chk("t4_ready_low", ins_ready, 1'b0);
            chk("t4_outs_stable", {outs_valid, outs}, 2'b11);
        end
        step(1, CV ^ 33'h1, 1, 0);
        step(0, '0, 0, 0);
        chk("t4_next_accepted", {outs_valid, outs}, 2'b10);
        step(0, '0, 1, 0);

        // 5: saturation on the 4-bit instance, then clear with a concurrent match
        step(0, '0, 1, 1);
        for (int i = 0; i < 20; i++) step(1, CV, 1, 0);
        step(0, '0, 1, 0);
        chk("t5_sat4", match_count4, 4'd15);
        chk("t5_count16", match_count, 16'd20);
        step(1, CV ^ 33'h2, 1, 0);
        step(1, CV, 1, 1);
        step(0, '0, 1, 0);
        chk("t5_clear_counts", {match_count, mismatch_count, err}, 33'd0);
        chk("t5_clear_outs", {outs_valid, outs}, 2'b11);

        // random phase
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0, 1: d = CV;
                2: d = CV ^ (33'd1 << $urandom_range(0, 32));
                default: d = {1'($urandom_range(0, 1)), 32'($urandom())};
            endcase
            step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 39) == 0));
        end

        // 6: async reset while a mismatch result is pending
        step(1, CV ^ 33'h4, 0, 0);
        step(0, '0, 0, 0);
        chk("t6_pre", {outs_valid, err}, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_outs", {outs_valid, outs, err}, 3'b000);
        chk("t6_async_counts", {match_count, mismatch_count}, 32'd0);
        chk("t6_async_counts4", {match_count4, mismatch_count4, err4}, 9'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1, CV, 1, 0);
        step(0, '0, 1, 0);
        chk("t6_recover", {outs_valid, outs, match_count}, 18'h30001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
